// File: rtl/mod_pingpong_sched.sv
// mod_pingpong_sched: read-side scheduler for the mapper's two-bank ping-pong
// symbol buffer. It tracks the write bank and the per-bank full flags, latches
// each bank's last address, and drains full banks in order towards the
// transform-precoding stage.
// Optional build macro: MOD_PP_STATS_EN adds the Blk_Cnt/Stall_Cnt counters.
module mod_pingpong_sched #(
  parameter int ADDR_WIDTH = 11,
  parameter int RD_LAT     = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Wr_En_IN,
  input  logic                  Switch_IN,
  input  logic [ADDR_WIDTH-1:0] Last_addr_IN,
  input  logic                  Mod_Done_IN,
  input  logic                  Rd_Ready,
  output logic                  Wr_Bank,
  output logic [1:0]            Bank_Full,
  output logic                  Stall,
  output logic                  Rd_En,
  output logic                  Rd_Bank,
  output logic [ADDR_WIDTH-1:0] Rd_Addr,
  output logic                  Rd_Valid,
  output logic                  Rd_Last,
  output logic                  Sched_Done,
`ifdef MOD_PP_STATS_EN
  output logic                  Overflow,
  output logic [15:0]           Blk_Cnt,
  output logic [15:0]           Stall_Cnt
`else
  output logic                  Overflow
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READ    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [1:0]            full_q, full_d;
  logic [ADDR_WIDTH-1:0] len_q [2];
  logic [ADDR_WIDTH-1:0] len_d [2];
  logic                  dirty_q, dirty_d;
  logic                  done_pend_q, done_pend_d;
  logic                  ovf_q, ovf_d;
  logic [RD_LAT-1:0]     vld_q, vld_d;
  logic [RD_LAT-1:0]     last_q, last_d;

  logic                  rd_en;
  logic                  rd_last_tag;
  logic [1:0]            rel_mask;
  logic [1:0]            full_post;
  logic                  switch_req;
  logic                  sw_accept;
  logic                  sw_reject;
  logic                  sched_done;

  // Saturating 16-bit increment used by the statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign rd_en       = (state_q == S_READ) && Rd_Ready;
  assign rd_last_tag = rd_en && (rd_addr_q == len_q[rd_bank_q]);

  // Read FSM next-state: wait for the current read bank, stream it, release it.
  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    rd_addr_d = rd_addr_q;
    rel_mask  = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d   = S_READ;
          rd_addr_d = '0;
        end
      end
      S_READ: begin
        if (rd_en) begin
          if (rd_last_tag) begin
            // Park the address at 0 so it never runs past the bank length.
            state_d   = S_RELEASE;
            rd_addr_d = '0;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      S_RELEASE: begin
        rel_mask[rd_bank_q] = 1'b1;
        rd_bank_d           = ~rd_bank_q;
        state_d             = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write side: accept or reject bank switches against the post-release flags.
  always_comb begin
    switch_req = Switch_IN || (Mod_Done_IN && (dirty_q || Wr_En_IN));
    full_post  = full_q & ~rel_mask;
    sw_accept  = switch_req && !full_post[wr_bank_q];
    sw_reject  = switch_req &&  full_post[wr_bank_q];
    full_d     = full_post;
    wr_bank_d  = wr_bank_q;
    len_d      = len_q;
    dirty_d    = dirty_q;
    ovf_d      = ovf_q || sw_reject;
    if (sw_accept) begin
      full_d[wr_bank_q] = 1'b1;
      len_d[wr_bank_q]  = Last_addr_IN;
      wr_bank_d         = ~wr_bank_q;
      dirty_d           = 1'b0;
    end else if (Wr_En_IN) begin
      dirty_d = 1'b1;
    end
  end

  // End-of-stream tracking: done fires once everything has drained.
  always_comb begin
    sched_done  = done_pend_q && (full_q == 2'b00) && (state_q == S_IDLE) && !(|vld_q);
    done_pend_d = Mod_Done_IN || (done_pend_q && !sched_done);
  end

  // Read-data valid/last shift matching the RAM read latency.
  always_comb begin
    vld_d     = vld_q;
    last_d    = last_q;
    vld_d[0]  = rd_en;
    last_d[0] = rd_last_tag;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      last_d[i] = last_q[i-1];
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      rd_bank_q   <= 1'b0;
      rd_addr_q   <= '0;
      wr_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      len_q[0]    <= '0;
      len_q[1]    <= '0;
      dirty_q     <= 1'b0;
      done_pend_q <= 1'b0;
      ovf_q       <= 1'b0;
      vld_q       <= '0;
      last_q      <= '0;
    end else begin
      state_q     <= state_d;
      rd_bank_q   <= rd_bank_d;
      rd_addr_q   <= rd_addr_d;
      wr_bank_q   <= wr_bank_d;
      full_q      <= full_d;
      len_q[0]    <= len_d[0];
      len_q[1]    <= len_d[1];
      dirty_q     <= dirty_d;
      done_pend_q <= done_pend_d;
      ovf_q       <= ovf_d;
      vld_q       <= vld_d;
      last_q      <= last_d;
    end
  end

  assign Wr_Bank    = wr_bank_q;
  assign Bank_Full  = full_q;
  assign Stall      = full_q[0] & full_q[1];
  assign Rd_En      = rd_en;
  assign Rd_Bank    = rd_bank_q;
  assign Rd_Addr    = rd_addr_q;
  assign Rd_Valid   = vld_q[RD_LAT-1];
  assign Rd_Last    = vld_q[RD_LAT-1] & last_q[RD_LAT-1];
  assign Sched_Done = sched_done;
  assign Overflow   = ovf_q;

`ifdef MOD_PP_STATS_EN
  logic [15:0] blk_cnt_q, stall_cnt_q;

  // Released-bank and stall-cycle counters, saturating.
  always_ff @(posedge CLK) begin
    if (RST) begin
      blk_cnt_q   <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      if (state_q == S_RELEASE) blk_cnt_q <= sat_inc16(blk_cnt_q);
      if (Stall)                stall_cnt_q <= sat_inc16(stall_cnt_q);
    end
  end

  assign Blk_Cnt   = blk_cnt_q;
  assign Stall_Cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mod_pingpong_sched.sv
// Directed bench for mod_pingpong_sched (ADDR_WIDTH=11, RD_LAT=1).
module tb_mod_pingpong_sched;
  localparam int AW = 11;

  logic          CLK = 1'b0;
  logic          RST;
  logic          Wr_En_IN;
  logic          Switch_IN;
  logic [AW-1:0] Last_addr_IN;
  logic          Mod_Done_IN;
  logic          Rd_Ready;
  logic          Wr_Bank;
  logic [1:0]    Bank_Full;
  logic          Stall;
  logic          Rd_En;
  logic          Rd_Bank;
  logic [AW-1:0] Rd_Addr;
  logic          Rd_Valid;
  logic          Rd_Last;
  logic          Sched_Done;
  logic          Overflow;
`ifdef MOD_PP_STATS_EN
  logic [15:0]   Blk_Cnt;
  logic [15:0]   Stall_Cnt;
`endif

  logic [20:0]   outs_w;
  int            n_vec = 0;
  int            n_mis = 0;

  always #5 CLK = ~CLK;

  mod_pingpong_sched #(.ADDR_WIDTH(AW), .RD_LAT(1)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .Wr_En_IN     (Wr_En_IN),
    .Switch_IN    (Switch_IN),
    .Last_addr_IN (Last_addr_IN),
    .Mod_Done_IN  (Mod_Done_IN),
    .Rd_Ready     (Rd_Ready),
    .Wr_Bank      (Wr_Bank),
    .Bank_Full    (Bank_Full),
    .Stall        (Stall),
    .Rd_En        (Rd_En),
    .Rd_Bank      (Rd_Bank),
    .Rd_Addr      (Rd_Addr),
    .Rd_Valid     (Rd_Valid),
    .Rd_Last      (Rd_Last),
    .Sched_Done   (Sched_Done),
`ifdef MOD_PP_STATS_EN
    .Overflow     (Overflow),
    .Blk_Cnt      (Blk_Cnt),
    .Stall_Cnt    (Stall_Cnt)
`else
    .Overflow     (Overflow)
`endif
  );

  assign outs_w = {Wr_Bank, Bank_Full, Stall, Rd_En, Rd_Bank, Rd_Valid,
                   Rd_Last, Sched_Done, Overflow, Rd_Addr};

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_in();
    Wr_En_IN     = 1'b0;
    Switch_IN    = 1'b0;
    Mod_Done_IN  = 1'b0;
    Last_addr_IN = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_a, n_en, n_done, last_en_c, done_c;
    idle_in();
    Rd_Ready = 1'b0;
    RST      = 1'b1;
    nxt();
    nxt();
    settle();
    check_vec("rst_outs", 32'(outs_w), 0);
    RST      = 1'b0;
    Rd_Ready = 1'b1;
    nxt();

    // Single bank of 4 symbols
    for (int i = 0; i < 4; i++) begin
      Wr_En_IN = 1'b1;
      nxt();
    end
    Wr_En_IN = 1'b0; Switch_IN = 1'b1; Last_addr_IN = 11'd3;
    nxt();
    idle_in();
    settle();
    check_vec("t1_full", 32'(Bank_Full), 1);
    check_vec("t1_wrb", 32'(Wr_Bank), 1);
    check_vec("t1_en_idle", 32'(Rd_En), 0);
    nxt();
    for (int k = 0; k < 4; k++) begin
      settle();
      check_vec("t1_en", 32'(Rd_En), 1);
      check_vec("t1_addr", 32'(Rd_Addr), k);
      check_vec("t1_vld", 32'(Rd_Valid), (k > 0) ? 1 : 0);
      check_vec("t1_last", 32'(Rd_Last), 0);
      nxt();
    end
    settle();
    check_vec("t1_rel_en", 32'(Rd_En), 0);
    check_vec("t1_rel_vld", 32'(Rd_Valid), 1);
    check_vec("t1_rel_last", 32'(Rd_Last), 1);
    check_vec("t1_rel_full", 32'(Bank_Full), 1);
    nxt();
    settle();
    check_vec("t1_done_full", 32'(Bank_Full), 0);
    check_vec("t1_rdbank", 32'(Rd_Bank), 1);
    check_vec("t1_vld_off", 32'(Rd_Valid), 0);
    check_vec("t1_nodone", 32'(Sched_Done), 0);
    nxt();

    // Back-pressure on bank 1, len 5
    Switch_IN = 1'b1; Last_addr_IN = 11'd5;
    nxt();
    idle_in();
    settle();
    check_vec("t2_full", 32'(Bank_Full), 2);
    check_vec("t2_wrb", 32'(Wr_Bank), 0);
    nxt();
    exp_a = 0; n_en = 0;
    for (int c = 0; c < 20 && n_en < 6; c++) begin
      Rd_Ready = (c % 2 == 0);
      settle();
      check_vec("t2_en", 32'(Rd_En), 32'(Rd_Ready));
      check_vec("t2_addr", 32'(Rd_Addr), exp_a);
      check_vec("t2_bank", 32'(Rd_Bank), 1);
      check_vec("t2_last", 32'(Rd_Last), 0);
      if (Rd_Ready) begin
        n_en++;
        if (exp_a < 5) exp_a++;
      end
      nxt();
    end
    check_vec("t2_en_cnt", n_en, 6);
    Rd_Ready = 1'b1;
    settle();
    check_vec("t2_rel_vld", 32'(Rd_Valid), 1);
    check_vec("t2_rel_last", 32'(Rd_Last), 1);
    nxt();
    settle();
    check_vec("t2_end_full", 32'(Bank_Full), 0);
    check_vec("t2_rdbank", 32'(Rd_Bank), 0);

    // Both banks full, then an ignored stall
    Rd_Ready = 1'b0;
    Switch_IN = 1'b1; Last_addr_IN = 11'd7;
    nxt();
    nxt();
    idle_in();
    settle();
    check_vec("t3_stall", 32'(Stall), 1);
    check_vec("t3_full", 32'(Bank_Full), 3);
    check_vec("t3_wrb", 32'(Wr_Bank), 0);
    check_vec("t3_ovf0", 32'(Overflow), 0);
    check_vec("t3_hold_en", 32'(Rd_En), 0);
    Switch_IN = 1'b1; Last_addr_IN = 11'd2;
    nxt();
    idle_in();
    settle();
    check_vec("t3_ovf1", 32'(Overflow), 1);
    check_vec("t3_wrb_keep", 32'(Wr_Bank), 0);
    check_vec("t3_full_keep", 32'(Bank_Full), 3);
    check_vec("t3_addr_hold", 32'(Rd_Addr), 0);

    // Reset in the middle of a stalled state
    RST = 1'b1;
    nxt();
    settle();
    check_vec("rst_mid", 32'(outs_w), 0);
    RST      = 1'b0;
    Rd_Ready = 1'b1;
    nxt();

    // Release of bank 0 coinciding with a switch into bank 0
    Switch_IN = 1'b1; Last_addr_IN = 11'd1;
    nxt();
    Last_addr_IN = 11'd2;
    nxt();
    idle_in();
    settle();
    check_vec("t4_en0", 32'(Rd_En), 1);
    check_vec("t4_addr0", 32'(Rd_Addr), 0);
    nxt();
    settle();
    check_vec("t4_addr1", 32'(Rd_Addr), 1);
    nxt();
    Switch_IN = 1'b1; Last_addr_IN = 11'd3;
    settle();
    check_vec("t4_rel_stall", 32'(Stall), 1);
    check_vec("t4_rel_last", 32'(Rd_Last), 1);
    nxt();
    idle_in();
    settle();
    check_vec("t4_full", 32'(Bank_Full), 3);
    check_vec("t4_wrb", 32'(Wr_Bank), 1);
    check_vec("t4_ovf", 32'(Overflow), 0);
    check_vec("t4_rdbank", 32'(Rd_Bank), 1);
    n_en = 0; n_done = 0;
    for (int c = 0; c < 40; c++) begin
      settle();
      if (Rd_En) n_en++;
      if (Sched_Done) n_done++;
      nxt();
    end
    settle();
    check_vec("t4_drain_en", n_en, 7);
    check_vec("t4_drain_nodone", n_done, 0);
    check_vec("t4_drain_full", 32'(Bank_Full), 0);
    nxt();

    // End of stream without a final Switch_IN
    for (int i = 0; i < 3; i++) begin
      Wr_En_IN = 1'b1;
      nxt();
    end
    Wr_En_IN = 1'b0; Mod_Done_IN = 1'b1; Last_addr_IN = 11'd2;
    nxt();
    idle_in();
    settle();
    check_vec("t5_full", 32'(Bank_Full), 2);
    check_vec("t5_wrb", 32'(Wr_Bank), 0);
    n_en = 0; n_done = 0; last_en_c = -1; done_c = -1;
    for (int c = 0; c < 20; c++) begin
      settle();
      if (Rd_En) begin
        n_en++;
        last_en_c = c;
      end
      if (Sched_Done) begin
        n_done++;
        done_c = c;
      end
      nxt();
    end
    check_vec("t5_reads", n_en, 3);
    check_vec("t5_done_cnt", n_done, 1);
    check_vec("t5_done_gap", done_c - last_en_c, 2);

    // Reset while reading address 5, then a one-symbol bank
    Switch_IN = 1'b1; Last_addr_IN = 11'd9;
    nxt();
    idle_in();
    nxt();
    for (int k = 0; k < 5; k++) begin
      settle();
      check_vec("t6_addr", 32'(Rd_Addr), k);
      nxt();
    end
    settle();
    check_vec("t6_addr5", 32'(Rd_Addr), 5);
    RST = 1'b1;
    nxt();
    RST = 1'b0;
    settle();
    check_vec("t6_rst_outs", 32'(outs_w), 0);
    Switch_IN = 1'b1; Last_addr_IN = 11'd0;
    nxt();
    idle_in();
    settle();
    check_vec("t6_full", 32'(Bank_Full), 1);
    check_vec("t6_wrb", 32'(Wr_Bank), 1);
    nxt();
    settle();
    check_vec("t6_en", 32'(Rd_En), 1);
    check_vec("t6_addr0", 32'(Rd_Addr), 0);
    check_vec("t6_bank0", 32'(Rd_Bank), 0);
    nxt();
    settle();
    check_vec("t6_one_en", 32'(Rd_En), 0);
    check_vec("t6_one_vld", 32'(Rd_Valid), 1);
    check_vec("t6_one_last", 32'(Rd_Last), 1);
    nxt();
    settle();
    check_vec("t6_end_full", 32'(Bank_Full), 0);
    check_vec("t6_nodone", 32'(Sched_Done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
